// File: rtl/mips_bus_if.sv
// Variable-latency bus interface between the multi-cycle MIPS core and memory.
// Optional bus timeout is enabled by defining MIPS_BUS_TIMEOUT_EN.
module mips_bus_if #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 TIMEOUT  = 64,
  parameter logic [DATA_W-1:0]  ERR_DATA = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_read,
  input  logic              core_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              bus_error,
  output logic [15:0]       wait_cycles,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_in,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_is_write;
  logic [15:0]         r_wait_cnt;
  logic [15:0]         r_wait_cycles;
  logic [DATA_W-1:0]   r_core_rdata;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_mem_out;
  logic                w_req;
  logic                w_expire;

  assign w_req = core_read | core_write;

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0] TMO_WAIT = (TIMEOUT > 65535) ? 16'hFFFF : 16'(TIMEOUT);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_bus_error;

  // Expiry on the TIMEOUT-th silent BUSY cycle; mem_ready in that cycle wins.
  assign w_expire = (r_state == S_BUSY) && !mem_ready && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt   <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= w_expire;
      if (r_state == S_IDLE && w_req)
        r_tmo_cnt <= '0;
      else if (r_state == S_BUSY && !mem_ready && !w_expire)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign bus_error = r_bus_error;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^ERR_DATA) ^ (TIMEOUT > 0);
  assign w_expire     = 1'b0;
  assign bus_error    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_next = S_BUSY;
      S_BUSY:  if (mem_ready || w_expire) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_read   = (r_state == S_BUSY) && !r_is_write;
    mem_write  = (r_state == S_BUSY) &&  r_is_write;
    core_stall = 1'b0;
    if (rst) begin
      unique case (r_state)
        S_IDLE:  core_stall = w_req;
        S_BUSY:  core_stall = 1'b1;
        default: core_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_is_write    <= 1'b0;
      r_wait_cnt    <= '0;
      r_wait_cycles <= '0;
      r_core_rdata  <= '0;
      r_address     <= '0;
      r_mem_out     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_address  <= core_addr;
            r_mem_out  <= core_wdata;
            r_is_write <= core_write;
            r_wait_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            if (!r_is_write) r_core_rdata <= mem_in;
            r_wait_cycles <= r_wait_cnt;
          end else if (w_expire) begin
`ifdef MIPS_BUS_TIMEOUT_EN
            if (!r_is_write) r_core_rdata <= ERR_DATA;
            r_wait_cycles <= TMO_WAIT;
`endif
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rdata  = r_core_rdata;
  assign wait_cycles = r_wait_cycles;
  assign address     = r_address;
  assign mem_out     = r_mem_out;

endmodule

// File: tb/tb_mips_bus_if.sv
// Scoreboard bench for mips_bus_if: stimulus pushes expected completions,
// a negedge monitor pops and checks them when core_stall falls.
module tb_mips_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_read, core_write;
  logic [31:0] core_addr, core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall, bus_error;
  logic [15:0] wait_cycles;
  logic [31:0] address, mem_out;
  logic        mem_read, mem_write;
  logic [31:0] mem_in;
  logic        mem_ready;

  always #5 clk = ~clk;

  mips_bus_if #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (4),
    .ERR_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_read  (core_read),
    .core_write (core_write),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .bus_error  (bus_error),
    .wait_cycles(wait_cycles),
    .address    (address),
    .mem_out    (mem_out),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_in     (mem_in),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] wait_c;
    logic        err;
    int unsigned n_rd;
    int unsigned n_wr;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count strobe cycles per access and check on completion.
  initial begin : monitor
    logic        prev_stall;
    int unsigned cnt_rd, cnt_wr;
    exp_t        e;
    prev_stall = 1'b0;
    cnt_rd = 0;
    cnt_wr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        cnt_rd = 0;
        cnt_wr = 0;
      end else begin
        if (mem_read)  cnt_rd++;
        if (mem_write) cnt_wr++;
        if (prev_stall && !core_stall) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("core_rdata",   core_rdata, e.rdata);
            chk("wait_cycles",  {16'd0, wait_cycles}, {16'd0, e.wait_c});
            chk("bus_error",    {31'd0, bus_error}, {31'd0, e.err});
            chk("mem_read_cyc", cnt_rd, e.n_rd);
            chk("mem_write_cyc", cnt_wr, e.n_wr);
          end
          cnt_rd = 0;
          cnt_wr = 0;
        end else if (bus_error) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_bus_error: got 1 expected 0 at %0t", $time);
        end
        prev_stall = core_stall;
      end
    end
  end

  // One access: request at T, mem_ready on the (k+1)-th BUSY cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int unsigned k, input logic hold);
    exp_t e;
    if (!wr) model_rdata = rdata;
    e.rdata  = model_rdata;
    e.wait_c = 16'(k);
    e.err    = 1'b0;
    e.n_rd   = wr ? 0 : k + 1;
    e.n_wr   = wr ? k + 1 : 0;
    sb.push_back(e);
    core_read  = rd;
    core_write = wr;
    core_addr  = addr;
    core_wdata = wdata;
    @(posedge clk); #1;
    for (int unsigned i = 0; i <= k; i++) begin
      if (i < 4) begin
        chk("address_stable", address, addr);
        chk("mem_out_stable", mem_out, wdata);
      end
      mem_ready = (i == k);
      mem_in    = (i == k) ? rdata : (32'hBAD0_0000 | i);
      core_addr = addr ^ 32'h0000_1000;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    mem_in    = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    if (!hold) begin
      core_read  = 1'b0;
      core_write = 1'b0;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst        = 1'b0;
    core_read  = 1'b1;
    core_write = 1'b0;
    core_addr  = 32'h0000_0010;
    core_wdata = 32'h0;
    mem_in     = 32'h0;
    mem_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_address",    address, 32'd0);
    chk("rst_mem_out",    mem_out, 32'd0);
    chk("rst_wait",       {16'd0, wait_cycles}, 32'd0);
    chk("rst_strobes",    {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_bus_error",  {31'd0, bus_error}, 32'd0);
    core_read = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;

    do_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 0, 1'b0);
    do_access(1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 32'hA5A5_0001, 1, 1'b1);
    do_access(1'b1, 1'b0, 32'h48, 32'h0, 32'h0000_00FF, 0, 1'b0);
    do_access(1'b1, 1'b1, 32'hC0, 32'h1111_2222, 32'h0, 2, 1'b0);
    do_access(1'b1, 1'b0, 32'hD0, 32'h0, 32'hCAFE_F00D, 2, 1'b0);

    // Reset during the second BUSY cycle
    core_read = 1'b1;
    core_addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b0;
    core_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_strobes",   {30'd0, mem_read, mem_write}, 32'd0);
    chk("midrst_rdata",     core_rdata, 32'd0);
    chk("midrst_wait",      {16'd0, wait_cycles}, 32'd0);
    chk("midrst_stall",     {31'd0, core_stall}, 32'd0);
    chk("midrst_bus_error", {31'd0, bus_error}, 32'd0);
    model_rdata = 32'd0;
    @(posedge clk); #1;
    chk("midrst_idle", {29'd0, mem_read, mem_write, core_stall}, 32'd0);

`ifdef MIPS_BUS_TIMEOUT_EN
    begin : timeout_read
      exp_t e;
      model_rdata = 32'hFFFF_FFFF;
      e.rdata  = 32'hFFFF_FFFF;
      e.wait_c = 16'd4;
      e.err    = 1'b1;
      e.n_rd   = 4;
      e.n_wr   = 0;
      sb.push_back(e);
      core_read = 1'b1;
      core_addr = 32'h300;
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;
      chk("tmo_stall_done", {31'd0, core_stall}, 32'd0);
      core_read = 1'b0;
      @(posedge clk); #1;
    end
    do_access(1'b1, 1'b0, 32'h304, 32'h0, 32'h7777_0003, 3, 1'b0);
`else
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 32'h0BAD_CAFE, 100, 1'b0);
`endif

    do_access(1'b1, 1'b0, 32'h500, 32'h0, 32'h5A5A_5A5A, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_if.md
# mips_bus_if

Parametrised bus interface unit between the multi-cycle MIPS core and memory. The first-generation core assumed memory answers in the same cycle. This block adds a variable-latency ready handshake: it registers each core access, stalls the core until memory completes, and returns captured read data. It also reports wait-state counts and, optionally, bus timeouts.

## Interface

Parameters:
- DATA_W, 32, width of data buses
- ADDR_W, 32, width of address bus
- TIMEOUT, 64, BUSY cycles without mem_ready before abort (only with timeout feature; must be ≥1)
- ERR_DATA, all ones, read data returned on timeout

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (rst=0 at a rising edge resets)
- core_read  in  1  core read request, held by core while stalled
- core_write  in  1  core write request, held by core while stalled
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_rdata  out  DATA_W  registered read data
- core_stall  out  1  freeze core controller state
- bus_error  out  1  one-cycle timeout flag
- wait_cycles  out  16  wait states of last completed access, saturating
- address  out  ADDR_W  registered memory address
- mem_out  out  DATA_W  registered memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_in  in  DATA_W  memory read data
- mem_ready  in  1  memory completion

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - core_stall = core_read | core_write (combinational).
  - On a request, latch core_addr, core_wdata and the access type into address/mem_out/type registers, clear the wait counter and go to BUSY.
  - If both core_read and core_write are high, the access is a write.
- BUSY:
  - mem_read / mem_write asserted per latched type; address and mem_out held stable; core_stall=1.
  - mem_ready=1: for a read, capture mem_in into core_rdata. Load wait_cycles from the wait counter and go to DONE.
  - mem_ready=0: the wait counter increments, saturating at 16'hFFFF.
- DONE:
  - Strobes low; core_stall=0 so the core advances one state; go to IDLE.
  - Core requests in DONE are ignored: they belong to the completed access.
- mem_ready outside BUSY is ignored.
- Writes leave core_rdata unchanged.
- Reset values: FSM=IDLE; core_rdata, address, mem_out, wait_cycles = 0; mem_read, mem_write, bus_error = 0. core_stall is 0 while reset is held.
- Reset mid-access: the access is abandoned at that edge, strobes drop, and no data or error is reported.

## Timing

- Request sampled in IDLE at cycle T. Strobes are high from T+1.
- If mem_ready is first high in BUSY cycle T+1+k, then:
  - DONE is T+2+k.
  - core_stall is high for cycles T..T+1+k and low in T+2+k.
  - core_rdata is valid from T+2+k until the next read completes.
  - wait_cycles = k.
- Minimum access: 2 stall cycles.
- Back-to-back accesses: the next request is sampled no earlier than T+3+k.
- address and mem_out change only on the IDLE→BUSY edge.

## Configuration

Macro: MIPS_BUS_TIMEOUT_EN.

With the macro defined:
- A TIMEOUT counter runs in BUSY.
- If TIMEOUT consecutive BUSY cycles pass without mem_ready, the next state is DONE with strobes dropped.
- For a read, core_rdata=ERR_DATA. For a write, memory state is undefined.
- bus_error=1 for exactly the DONE cycle, and wait_cycles=TIMEOUT (saturated).
- mem_ready arriving in the same cycle as expiry wins: normal completion, no error.

Without the macro:
- BUSY waits indefinitely; no timeout counter is synthesised.
- bus_error is tied to 0.

## Test plan

- Zero-wait read: core_read=1, addr=0x40 at T; mem_in=0x1234_5678 with mem_ready=1 at T+1 → mem_read high T+1 only; stall high T, T+1; core_rdata=0x12345678 and stall=0 at T+2; wait_cycles=0.
- Wait-state write: core_write=1, addr=0x80, wdata=0xDEADBEEF; mem_ready low 3 cycles then high → address/mem_out stable across 4 BUSY cycles; mem_write high 4 cycles; wait_cycles=3; core_rdata unchanged.
- Request held through DONE: core_read held high across completion → exactly one memory access; a new access starts only after returning to IDLE.
- Both requests high: core_read=core_write=1 → mem_write asserted, mem_read stays 0.
- Reset mid-access: rst=0 during the second BUSY cycle → next cycle strobes=0, core_rdata=0, wait_cycles=0, FSM in IDLE; no error flag.
- Timeout (MIPS_BUS_TIMEOUT_EN, TIMEOUT=4): read with mem_ready never high → strobe high 4 cycles; then bus_error=1 for one cycle, core_rdata=0xFFFFFFFF, wait_cycles=4, stall low. Without the macro: still stalled after 100 cycles.
